// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared definitions for the FPmul result sink.
//   FP_W / EXP_MSB / EXP_LSB / MAN_W  IEEE-754 single-precision field layout
//   fp_class_e                        2-bit result class carried beside each FIFO entry
//   fp_classify()                     class of a result, given its magnitude bits
//   fp_is_denorm()                    denormal flag, given its magnitude bits
// Denormals are reported as FP_NORMAL. They are counted separately.
package fpmul_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam int unsigned MAN_W   = 23;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'd0,
    FP_ZERO   = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

  // The sign bit never affects the class, so only the magnitude is passed in.
  function automatic fp_class_e fp_classify(input logic [FP_W-2:0] mag);
    logic [EXP_MSB-EXP_LSB:0] exp_f;
    logic [MAN_W-1:0]         man_f;
    exp_f = mag[EXP_MSB:EXP_LSB];
    man_f = mag[MAN_W-1:0];
    if (exp_f == '1)
      fp_classify = (man_f != '0) ? FP_NAN : FP_INF;
    else if ((exp_f == '0) && (man_f == '0))
      fp_classify = FP_ZERO;
    else
      fp_classify = FP_NORMAL;
  endfunction

  function automatic logic fp_is_denorm(input logic [FP_W-2:0] mag);
    fp_is_denorm = (mag[EXP_MSB:EXP_LSB] == '0) && (mag[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fpmul_sync_fifo.sv
// fpmul_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (pointers and level only)
//   i_push   in   write i_din. It is ignored when the FIFO is full and no pop occurs on the same edge.
//   i_din    in   WIDTH-bit write data
//   i_pop    in   remove head. It is ignored when the FIFO is empty.
//   o_dout   out  head entry. It reads 0 while the FIFO is empty.
//   o_full   out  level == DEPTH
//   o_empty  out  level == 0
//   o_level  out  occupancy, $clog2(DEPTH)+1 bits
module fpmul_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  // When the FIFO is full, a same-edge pop frees the head slot. The write lands in that slot,
  // which is the one at r_wr_ptr because r_wr_ptr equals r_rd_ptr when the FIFO is full.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fpmul_result_sink.sv
// fpmul_result_sink: result side of the pipelined FP multiplier.
// The block delays IN_VALID by LATENCY cycles. On the matching edge it captures FP_Z,
// classifies it, counts it, and queues it in a FWFT FIFO. The FIFO drains over a valid/ready port.
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   IN_VALID     in   operands entering the multiplier this cycle are real
//   FP_Z         in   multiplier result (IEEE-754 single)
//   OUT_VALID    out  FIFO head valid
//   OUT_READY    in   consumer accepts head
//   OUT_DATA     out  head result
//   OUT_CLASS    out  head class: 0 normal, 1 zero, 2 inf, 3 NaN
//   LEVEL        out  FIFO occupancy
//   RESULT_CNT   out  results captured (including dropped ones)
//   DROP_CNT     out  results lost to a full FIFO
//   NAN_CNT / INF_CNT / ZERO_CNT / DENORM_CNT  out  per-class capture counts
//   OVERFLOW     out  sticky: at least one drop since reset
// All counters saturate at all-ones.
module fpmul_result_sink
  import fpmul_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  input  logic [31:0]            FP_Z,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [31:0]            OUT_DATA,
  output logic [1:0]             OUT_CLASS,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic [CNT_W-1:0]       RESULT_CNT,
  output logic [CNT_W-1:0]       DROP_CNT,
  output logic [CNT_W-1:0]       NAN_CNT,
  output logic [CNT_W-1:0]       INF_CNT,
  output logic [CNT_W-1:0]       ZERO_CNT,
  output logic [CNT_W-1:0]       DENORM_CNT,
  output logic                   OVERFLOW
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [LATENCY-1:0]  r_tag;
  logic [CNT_W-1:0]    r_result_cnt;
  logic [CNT_W-1:0]    r_drop_cnt;
  logic [CNT_W-1:0]    r_nan_cnt;
  logic [CNT_W-1:0]    r_inf_cnt;
  logic [CNT_W-1:0]    r_zero_cnt;
  logic [CNT_W-1:0]    r_denorm_cnt;
  logic                r_overflow;

  logic                w_strobe;
  fp_class_e           w_class;
  logic                w_denorm;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic [FP_W+1:0]     w_fifo_din;
  logic [FP_W+1:0]     w_fifo_dout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + CNT_ONE;
  endfunction

  // Tag pipeline: bit i high means the operands sampled i+1 edges ago were valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= IN_VALID;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_strobe   = r_tag[LATENCY-1];
  assign w_class    = fp_classify(FP_Z[FP_W-2:0]);
  assign w_denorm   = fp_is_denorm(FP_Z[FP_W-2:0]);
  assign w_fifo_din = {w_class, FP_Z};

  assign OUT_VALID  = !w_empty;
  assign w_pop      = OUT_VALID && OUT_READY;
  assign w_drop     = w_strobe && w_full && !w_pop;

  fpmul_sync_fifo #(
    .WIDTH (FP_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_strobe),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (LEVEL)
  );

  assign OUT_DATA  = w_fifo_dout[FP_W-1:0];
  assign OUT_CLASS = w_fifo_dout[FP_W+1:FP_W];

  // The block counts every capture, including a capture that is dropped afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result_cnt <= '0;
      r_drop_cnt   <= '0;
      r_nan_cnt    <= '0;
      r_inf_cnt    <= '0;
      r_zero_cnt   <= '0;
      r_denorm_cnt <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_strobe) begin
        r_result_cnt <= sat_inc(r_result_cnt);
        unique case (w_class)
          FP_NAN:    r_nan_cnt  <= sat_inc(r_nan_cnt);
          FP_INF:    r_inf_cnt  <= sat_inc(r_inf_cnt);
          FP_ZERO:   r_zero_cnt <= sat_inc(r_zero_cnt);
          FP_NORMAL: if (w_denorm) r_denorm_cnt <= sat_inc(r_denorm_cnt);
        endcase
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_overflow <= 1'b1;
      end
    end
  end

  assign RESULT_CNT = r_result_cnt;
  assign DROP_CNT   = r_drop_cnt;
  assign NAN_CNT    = r_nan_cnt;
  assign INF_CNT    = r_inf_cnt;
  assign ZERO_CNT   = r_zero_cnt;
  assign DENORM_CNT = r_denorm_cnt;
  assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_fpmul_result_sink.sv
module tb_fpmul_result_sink;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] FP_Z = '0;
  logic        OUT_READY = 1'b0;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic [1:0]  OUT_CLASS;
  logic [3:0]  LEVEL;
  logic [CNT_W-1:0] RESULT_CNT, DROP_CNT, NAN_CNT, INF_CNT, ZERO_CNT, DENORM_CNT;
  logic        OVERFLOW;

  fpmul_result_sink #(.LATENCY(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .FP_Z       (FP_Z),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_CLASS  (OUT_CLASS),
    .LEVEL      (LEVEL),
    .RESULT_CNT (RESULT_CNT),
    .DROP_CNT   (DROP_CNT),
    .NAN_CNT    (NAN_CNT),
    .INF_CNT    (INF_CNT),
    .ZERO_CNT   (ZERO_CNT),
    .DENORM_CNT (DENORM_CNT),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] v; int unsigned due; } pend_t;
  typedef struct { logic [31:0] d; logic [1:0] c; } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  int unsigned n_vec = 0, n_miscmp = 0;
  int unsigned cyc = 0;
  int unsigned m_res, m_drop, m_nan, m_inf, m_zero, m_den;
  logic        m_ovf;
  logic        fresh;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [1:0] ref_class(input logic [31:0] z);
    if (z[30:23] == 8'hFF) return (z[22:0] != 0) ? 2'd3 : 2'd2;
    if (z[30:23] == 8'h00 && z[22:0] == 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One clock: drive inputs for edge 'cyc', update the model, then check after the edge.
  task automatic tick(input logic rst, input logic iv, input logic [31:0] val, input logic rdy);
    logic        cap, pop;
    logic [31:0] z;
    pend_t       p;
    exp_t        e;
    cap = (pend.size() > 0) && (pend[0].due == cyc);
    z   = $urandom();
    if (cap) begin
      p = pend.pop_front();
      z = p.v;
    end
    RST = rst; IN_VALID = iv; FP_Z = z; OUT_READY = rdy;
    pop = !rst && rdy && (exp_q.size() > 0);
    if (pop) begin
      check_eq("head_data", OUT_DATA, exp_q[0].d);
      check_eq("head_class", {30'd0, OUT_CLASS}, {30'd0, exp_q[0].c});
    end
    if (rst) begin
      pend.delete(); exp_q.delete();
      m_res = 0; m_drop = 0; m_nan = 0; m_inf = 0; m_zero = 0; m_den = 0;
      m_ovf = 1'b0; fresh = 1'b1;
    end else begin
      if (iv) begin
        p.v = val; p.due = cyc + LAT;
        pend.push_back(p);
      end
      if (cap) begin
        m_res = sat(m_res);
        case (ref_class(z))
          2'd3: m_nan  = sat(m_nan);
          2'd2: m_inf  = sat(m_inf);
          2'd1: m_zero = sat(m_zero);
          default: if (z[30:23] == 0) m_den = sat(m_den);
        endcase
      end
      if (cap && !(exp_q.size() < DEPTH || pop)) begin
        m_drop = sat(m_drop);
        m_ovf  = 1'b1;
      end
      if (pop) e = exp_q.pop_front();
      if (cap && (exp_q.size() < DEPTH)) begin
        e.d = z; e.c = ref_class(z);
        exp_q.push_back(e);
        fresh = 1'b0;
      end
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_eq("out_valid", {31'd0, OUT_VALID}, {31'd0, exp_q.size() > 0});
    check_eq("level", {28'd0, LEVEL}, exp_q.size());
    check_eq("result_cnt", {16'd0, RESULT_CNT}, m_res);
    check_eq("drop_cnt", {16'd0, DROP_CNT}, m_drop);
    check_eq("nan_cnt", {16'd0, NAN_CNT}, m_nan);
    check_eq("inf_cnt", {16'd0, INF_CNT}, m_inf);
    check_eq("zero_cnt", {16'd0, ZERO_CNT}, m_zero);
    check_eq("denorm_cnt", {16'd0, DENORM_CNT}, m_den);
    check_eq("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
    if (fresh && exp_q.size() == 0) begin
      check_eq("data_after_rst", OUT_DATA, 32'd0);
      check_eq("class_after_rst", {30'd0, OUT_CLASS}, 32'd0);
    end
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, 32'd0, rdy);
  endtask

  logic [31:0] cls_vals [5];

  initial begin
    cls_vals[0] = 32'h7FC00000; cls_vals[1] = 32'hFF800000; cls_vals[2] = 32'h80000000;
    cls_vals[3] = 32'h00000001; cls_vals[4] = 32'h3F800000;
    @(negedge CLK);
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 32'd0, 1'b0);
    while (cyc < 10) tick(1'b0, 1'b0, 32'd0, 1'b1);

    // Single sample issued at edge 10, captured at edge 14, then popped
    tick(1'b0, 1'b1, 32'h40C00000, 1'b1);
    idle(6, 1'b1);

    // Every class back to back
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, cls_vals[i], 1'b1);
    idle(8, 1'b1);

    // Overflow: ten captures with the consumer stalled
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 32'h41000000 + i, 1'b0);
    idle(6, 1'b0);

    // Full FIFO with push and pop on the same edge
    tick(1'b0, 1'b1, 32'h42AA0000, 1'b0);
    idle(3, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b1);
    idle(2, 1'b0);
    idle(12, 1'b1);

    // Gapped stream 1,0,1,1
    tick(1'b0, 1'b1, 32'h3E000001, 1'b1);
    tick(1'b0, 1'b0, 32'h3E000002, 1'b1);
    tick(1'b0, 1'b1, 32'h3E000003, 1'b1);
    tick(1'b0, 1'b1, 32'h3E000004, 1'b1);
    idle(8, 1'b1);

    // Random operands and back-pressure
    for (int i = 0; i < 40; i++)
      tick(1'b0, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
    idle(16, 1'b1);

    // Reset mid-flight: FIFO holds entries and one tag is in flight
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'h40400000 + i, 1'b0);
    idle(5, 1'b0);
    tick(1'b0, 1'b1, 32'h4B000000, 1'b0);
    tick(1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 32'd0, 1'b1);
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
